// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the two-master GPIO bus arbiter.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the GPIO slave port.
interface gpio_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          m0_req_i;
    logic          m0_we_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_data_i;
    logic          m0_gnt_o;
    logic [DW-1:0] m0_data_o;

    logic          m1_req_i;
    logic          m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i;
    logic          m1_gnt_o;
    logic [DW-1:0] m1_data_o;

    logic          s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o;
    logic [DW-1:0] s_data_i;

    // Arbiter view: master requests and GPIO read data come in.
    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_data_i,
        input  s_data_i,
        output m0_gnt_o, m0_data_o, m1_gnt_o, m1_data_o,
        output s_we_o, s_addr_o, s_data_o
    );

    // Fabric/GPIO view: drives requests and read data, observes the rest.
    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_data_i,
        output s_data_i,
        input  m0_gnt_o, m0_data_o, m1_gnt_o, m1_data_o,
        input  s_we_o, s_addr_o, s_data_o
    );

endinterface

// File: rtl/gpio_arb_mux.sv
// Slave-side request mux and read-return steering, selected by arbiter state.
module gpio_arb_mux
    import gpio_arb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  arb_state_e    state_i,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    input  logic [DW-1:0] s_data_i,
    output logic          s_we_o,
    output logic [AW-1:0] s_addr_o,
    output logic [DW-1:0] s_data_o,
    output logic [DW-1:0] m0_data_o,
    output logic [DW-1:0] m1_data_o
);

    always_comb begin
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_data_o = '0;
        m1_data_o = '0;
        case (state_i)
            StOwn0: begin
                s_we_o    = m0_we_i & m0_req_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                m0_data_o = s_data_i;
            end
            StOwn1: begin
                s_we_o    = m1_we_i & m1_req_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                m1_data_o = s_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin arbiter for the GPIO slave port with a hold-time cap.
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,  // must be >= 1
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
) (
    input logic               clk,
    input logic               rst,
    gpio_bus_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);
    localparam logic [CntW-1:0] HoldMax  = CntW'(MAX_HOLD);

    arb_state_e      state_q, state_d;
    logic            gnt0_q, gnt1_q;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            last_owner_q, last_owner_d;
    logic            hold_expired;

    // >= rather than ==: a counter saturated during an uncontended run must
    // still yield as soon as the other master shows up.
    assign hold_expired = (hold_cnt_q >= HoldLast);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.m0_req_i && bus.m1_req_i) begin
                    state_d = (last_owner_q == M0) ? StOwn1 : StOwn0;
                end else if (bus.m0_req_i) begin
                    state_d = StOwn0;
                end else if (bus.m1_req_i) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!bus.m0_req_i) begin
                    state_d = bus.m1_req_i ? StOwn1 : StIdle;
                end else if (bus.m1_req_i && hold_expired) begin
                    state_d = StOwn1;
                end
            end
            StOwn1: begin
                if (!bus.m1_req_i) begin
                    state_d = bus.m0_req_i ? StOwn0 : StIdle;
                end else if (bus.m0_req_i && hold_expired) begin
                    state_d = StOwn0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        if (state_d != state_q) begin
            hold_cnt_d = '0;
            if (state_d == StOwn0) last_owner_d = M0;
            if (state_d == StOwn1) last_owner_d = M1;
        end else if (state_q != StIdle && hold_cnt_q != HoldMax) begin
            hold_cnt_d = hold_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            hold_cnt_q   <= '0;
            last_owner_q <= M1;  // m0 wins the first tie
        end else begin
            state_q      <= state_d;
            gnt0_q       <= (state_d == StOwn0);
            gnt1_q       <= (state_d == StOwn1);
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.m0_gnt_o = gnt0_q;
    assign bus.m1_gnt_o = gnt1_q;

    gpio_arb_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .state_i  (state_q),
        .m0_req_i (bus.m0_req_i),
        .m0_we_i  (bus.m0_we_i),
        .m0_addr_i(bus.m0_addr_i),
        .m0_data_i(bus.m0_data_i),
        .m1_req_i (bus.m1_req_i),
        .m1_we_i  (bus.m1_we_i),
        .m1_addr_i(bus.m1_addr_i),
        .m1_data_i(bus.m1_data_i),
        .s_data_i (bus.s_data_i),
        .s_we_o   (bus.s_we_o),
        .s_addr_o (bus.s_addr_o),
        .s_data_o (bus.s_data_o),
        .m0_data_o(bus.m0_data_o),
        .m1_data_o(bus.m1_data_o)
    );

endmodule
